// File: rtl/cmp_pipe_if.sv
// Request/result handshake bundle for cmp_pipe: operands and tag in, flags and tag out.
// The requester drives the operand channel and result-ready; the comparator drives the rest.
interface cmp_pipe_if #(
    parameter int WIDTH = 32,
    parameter int ID_W  = 4
);
    logic             i_in_valid;
    logic             o_in_ready;
    logic [WIDTH-1:0] i_rs1_data;
    logic [WIDTH-1:0] i_rs2_data;
    logic             i_signed;
    logic [ID_W-1:0]  i_id;
    logic             o_out_valid;
    logic             i_out_ready;
    logic             o_less;
    logic             o_equal;
    logic             o_greater;
    logic [ID_W-1:0]  o_id;

    modport master (
        output i_in_valid, i_rs1_data, i_rs2_data, i_signed, i_id, i_out_ready,
        input  o_in_ready, o_out_valid, o_less, o_equal, o_greater, o_id
    );

    modport slave (
        input  i_in_valid, i_rs1_data, i_rs2_data, i_signed, i_id, i_out_ready,
        output o_in_ready, o_out_valid, o_less, o_equal, o_greater, o_id
    );
endinterface

// File: rtl/cmp_pipe.sv
// Pipelined signed/unsigned magnitude comparator with valid/ready on both sides.
// The whole pipe advances or stalls as one unit; a wrapping counter tallies delivered results.
module cmp_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2,
    parameter int ID_W    = 4,
    parameter int COUNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    cmp_pipe_if.slave          bus,
    output logic [COUNT_W-1:0] o_count
);

    if (WIDTH < 2) begin : g_bad_width
        $error("cmp_pipe: WIDTH must be at least 2");
    end
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("cmp_pipe: LATENCY must be in 1..4");
    end
    if (ID_W < 1) begin : g_bad_id_w
        $error("cmp_pipe: ID_W must be at least 1");
    end

    // Flags are packed as {less, equal, greater}. Operands are widened by one bit so a
    // single signed compare covers both modes: sign-extend when signed, zero-extend otherwise.
    function automatic logic [2:0] compare(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             is_signed
    );
        logic signed [WIDTH:0] a_ext;
        logic signed [WIDTH:0] b_ext;
        logic                  lt;
        logic                  eq;
        a_ext = $signed({is_signed & a[WIDTH-1], a});
        b_ext = $signed({is_signed & b[WIDTH-1], b});
        lt    = (a_ext < b_ext);
        eq    = (a == b);
        return {lt, eq, !lt && !eq};
    endfunction

    logic              advance;
    logic [2:0]        flg_p0;
    logic              vld_p [1:LATENCY];
    logic [2:0]        flg_p [1:LATENCY];
    logic [ID_W-1:0]   id_p  [1:LATENCY];

    // Stage 0: combinational compare on the offered operands
    assign flg_p0  = compare(bus.i_rs1_data, bus.i_rs2_data, bus.i_signed);
    assign advance = !vld_p[LATENCY] || bus.i_out_ready;

    assign bus.o_in_ready = advance;

    // Stages 1..LATENCY: valid bits are the only reset state
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int s = 1; s <= LATENCY; s++) begin
                vld_p[s] <= 1'b0;
            end
        end else if (advance) begin
            vld_p[1] <= bus.i_in_valid;
            for (int s = 2; s <= LATENCY; s++) begin
                vld_p[s] <= vld_p[s-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (advance) begin
            flg_p[1] <= flg_p0;
            id_p[1]  <= bus.i_id;
            for (int s = 2; s <= LATENCY; s++) begin
                flg_p[s] <= flg_p[s-1];
                id_p[s]  <= id_p[s-1];
            end
        end
    end

    // Output: flags and tag are masked by valid so an empty slot always reads as zero
    assign bus.o_out_valid = vld_p[LATENCY];
    assign bus.o_less      = vld_p[LATENCY] & flg_p[LATENCY][2];
    assign bus.o_equal     = vld_p[LATENCY] & flg_p[LATENCY][1];
    assign bus.o_greater   = vld_p[LATENCY] & flg_p[LATENCY][0];
    assign bus.o_id        = vld_p[LATENCY] ? id_p[LATENCY] : '0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_count <= '0;
        end else if (vld_p[LATENCY] && bus.i_out_ready) begin
            o_count <= o_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cmp_pipe.sv
// Directed bench for cmp_pipe: reset, sign modes, back-pressure, mid-stream reset,
// counter wrap, per-latency timing and a randomised stream against a scoreboard.
module tb_cmp_pipe;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    cmp_pipe_if #(.WIDTH(32), .ID_W(4)) bus  ();
    cmp_pipe_if #(.WIDTH(8),  .ID_W(4)) bus1 ();
    cmp_pipe_if #(.WIDTH(8),  .ID_W(4)) bus4 ();
    logic [3:0] count;
    logic [7:0] count1;
    logic [7:0] count4;

    cmp_pipe #(.WIDTH(32), .LATENCY(2), .ID_W(4), .COUNT_W(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus), .o_count(count)
    );
    cmp_pipe #(.WIDTH(8), .LATENCY(1), .ID_W(4), .COUNT_W(8)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus1), .o_count(count1)
    );
    cmp_pipe #(.WIDTH(8), .LATENCY(4), .ID_W(4), .COUNT_W(8)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus4), .o_count(count4)
    );

    // Sign-mode vectors: expected flags {less, equal, greater} worked out by hand
    logic [31:0] sv_a [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                              32'h8000_0000, 32'h8000_0000, 32'h0000_0005};
    logic [31:0] sv_b [7] = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 32'h8000_0000,
                              32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005};
    logic        sv_s [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  sv_e [7] = '{3'b100, 3'b001, 3'b010, 3'b010, 3'b100, 3'b001, 3'b010};

    function automatic logic [2:0] ref_cmp(input logic [7:0] a, input logic [7:0] b, input logic s);
        int ai;
        int bi;
        ai = s ? int'($signed(a)) : int'(a);
        bi = s ? int'($signed(b)) : int'(b);
        return {ai < bi, ai == bi, ai > bi};
    endfunction

    task automatic idle_all();
        bus.i_in_valid = 1'b0;  bus.i_rs1_data = '0;  bus.i_rs2_data = '0;
        bus.i_signed = 1'b0;    bus.i_id = '0;        bus.i_out_ready = 1'b1;
        bus1.i_in_valid = 1'b0; bus1.i_rs1_data = '0; bus1.i_rs2_data = '0;
        bus1.i_signed = 1'b0;   bus1.i_id = '0;       bus1.i_out_ready = 1'b1;
        bus4.i_in_valid = 1'b0; bus4.i_rs1_data = '0; bus4.i_rs2_data = '0;
        bus4.i_signed = 1'b0;   bus4.i_id = '0;       bus4.i_out_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_all();
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_all();
        rst_n = 1'b0;
        bus.i_in_valid = 1'b1; bus.i_rs1_data = 32'd3; bus.i_rs2_data = 32'd7;
        bus.i_id = 4'd6; bus.i_out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        n_checks++; if (bus.o_out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %b want 0", bus.o_out_valid); end
        n_checks++; if ({bus.o_less, bus.o_equal, bus.o_greater} !== 3'b000) begin n_errors++; $display("FAIL rst_flags: got %b want 000", {bus.o_less, bus.o_equal, bus.o_greater}); end
        n_checks++; if (bus.o_id !== 4'd0) begin n_errors++; $display("FAIL rst_id: got %0d want 0", bus.o_id); end
        n_checks++; if (count !== 4'd0) begin n_errors++; $display("FAIL rst_count: got %0d want 0", count); end
        n_checks++; if (bus.o_in_ready !== 1'b1) begin n_errors++; $display("FAIL rst_in_ready: got %b want 1", bus.o_in_ready); end
        rst_n = 1'b1;
        bus.i_in_valid = 1'b0; bus.i_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.o_out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_no_capture: got %b want 0", bus.o_out_valid); end
    endtask

    task automatic test_unsigned_basic();
        do_reset();
        bus.i_in_valid = 1'b1; bus.i_rs1_data = 32'd3; bus.i_rs2_data = 32'd7;
        bus.i_signed = 1'b0; bus.i_id = 4'd5;
        #1;
        n_checks++; if (bus.o_in_ready !== 1'b1) begin n_errors++; $display("FAIL basic_in_ready: got %b want 1", bus.o_in_ready); end
        @(posedge clk); #1;
        bus.i_in_valid = 1'b0;
        #1;
        n_checks++; if (bus.o_out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_early: got %b want 0", bus.o_out_valid); end
        @(posedge clk); #2;
        n_checks++; if ({bus.o_out_valid, bus.o_less, bus.o_equal, bus.o_greater} !== 4'b1100) begin n_errors++; $display("FAIL basic_flags: got %b want 1100", {bus.o_out_valid, bus.o_less, bus.o_equal, bus.o_greater}); end
        n_checks++; if (bus.o_id !== 4'd5) begin n_errors++; $display("FAIL basic_id: got %0d want 5", bus.o_id); end
        n_checks++; if (count !== 4'd0) begin n_errors++; $display("FAIL basic_count_pre: got %0d want 0", count); end
        @(posedge clk); #2;
        n_checks++; if (count !== 4'd1) begin n_errors++; $display("FAIL basic_count_post: got %0d want 1", count); end
        n_checks++; if (bus.o_out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_drained: got %b want 0", bus.o_out_valid); end
    endtask

    task automatic test_signed_modes();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i < 7) begin
                bus.i_in_valid = 1'b1; bus.i_rs1_data = sv_a[i]; bus.i_rs2_data = sv_b[i];
                bus.i_signed = sv_s[i]; bus.i_id = 4'(i);
            end else begin
                bus.i_in_valid = 1'b0;
            end
            #1;
            if (i >= 2) begin
                n_checks++; if ({bus.o_out_valid, bus.o_less, bus.o_equal, bus.o_greater} !== {1'b1, sv_e[i-2]}) begin n_errors++; $display("FAIL sign_flags[%0d]: got %b want %b", i-2, {bus.o_out_valid, bus.o_less, bus.o_equal, bus.o_greater}, {1'b1, sv_e[i-2]}); end
                n_checks++; if (bus.o_id !== 4'(i-2)) begin n_errors++; $display("FAIL sign_id[%0d]: got %0d want %0d", i-2, bus.o_id, i-2); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int         sent = 0;
        int         rcvd = 0;
        logic [2:0] hold_f = '0;
        logic [3:0] hold_id = '0;
        logic [2:0] exp_f;
        do_reset();
        for (int cyc = 0; cyc < 24; cyc++) begin
            bus.i_in_valid  = (sent < 8);
            bus.i_rs1_data  = 32'(sent);
            bus.i_rs2_data  = 32'd3;
            bus.i_signed    = 1'b0;
            bus.i_id        = 4'(sent);
            bus.i_out_ready = !(cyc >= 4 && cyc <= 6);
            #1;
            n_checks++; if (bus.o_in_ready !== (cyc < 4 || cyc > 6)) begin n_errors++; $display("FAIL bp_in_ready[c%0d]: got %b want %b", cyc, bus.o_in_ready, (cyc < 4 || cyc > 6)); end
            if (cyc == 4) begin
                hold_f  = {bus.o_less, bus.o_equal, bus.o_greater};
                hold_id = bus.o_id;
                n_checks++; if (bus.o_out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_stall_valid: got %b want 1", bus.o_out_valid); end
            end
            if (cyc == 5 || cyc == 6) begin
                n_checks++; if ({bus.o_out_valid, bus.o_less, bus.o_equal, bus.o_greater, bus.o_id} !== {1'b1, hold_f, hold_id}) begin n_errors++; $display("FAIL bp_hold[c%0d]: got %b want %b", cyc, {bus.o_out_valid, bus.o_less, bus.o_equal, bus.o_greater, bus.o_id}, {1'b1, hold_f, hold_id}); end
            end
            if (bus.o_out_valid && bus.i_out_ready) begin
                exp_f = (rcvd < 3) ? 3'b100 : (rcvd == 3) ? 3'b010 : 3'b001;
                n_checks++; if ({bus.o_less, bus.o_equal, bus.o_greater, bus.o_id} !== {exp_f, 4'(rcvd)}) begin n_errors++; $display("FAIL bp_result[%0d]: got %b want %b", rcvd, {bus.o_less, bus.o_equal, bus.o_greater, bus.o_id}, {exp_f, 4'(rcvd)}); end
                rcvd++;
            end
            if (bus.i_in_valid && bus.o_in_ready) sent++;
            @(posedge clk); #1;
        end
        n_checks++; if (rcvd != 8) begin n_errors++; $display("FAIL bp_received: got %0d want 8", rcvd); end
        n_checks++; if (sent != 8) begin n_errors++; $display("FAIL bp_sent: got %0d want 8", sent); end
        n_checks++; if (count !== 4'd8) begin n_errors++; $display("FAIL bp_count: got %0d want 8", count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.i_in_valid = 1'b1; bus.i_rs1_data = 32'd1; bus.i_rs2_data = 32'd1; bus.i_id = 4'd1;
        @(posedge clk); #1;
        bus.i_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (count !== 4'd1) begin n_errors++; $display("FAIL midrst_count_pre: got %0d want 1", count); end
        bus.i_out_ready = 1'b0;
        bus.i_in_valid = 1'b1; bus.i_id = 4'd9;
        @(posedge clk); #1;
        bus.i_id = 4'd10;
        @(posedge clk); #1;
        bus.i_in_valid = 1'b0;
        #1;
        n_checks++; if ({bus.o_out_valid, bus.o_id} !== {1'b1, 4'd9}) begin n_errors++; $display("FAIL midrst_inflight: got %b want %b", {bus.o_out_valid, bus.o_id}, {1'b1, 4'd9}); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++; if (bus.o_out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_valid: got %b want 0", bus.o_out_valid); end
        n_checks++; if (count !== 4'd0) begin n_errors++; $display("FAIL midrst_count: got %0d want 0", count); end
        n_checks++; if (bus.o_id !== 4'd0) begin n_errors++; $display("FAIL midrst_id: got %0d want 0", bus.o_id); end
        bus.i_out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_checks++; if (bus.o_out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_ghost[c%0d]: got valid %b id %0d want 0", c, bus.o_out_valid, bus.o_id); end
        end
    endtask

    task automatic test_count_wrap();
        do_reset();
        for (int i = 0; i < 21; i++) begin
            bus.i_in_valid = (i < 17);
            bus.i_rs1_data = 32'(i); bus.i_rs2_data = 32'd8; bus.i_id = 4'(i);
            #1;
            if (i == 18) begin
                n_checks++; if (count !== 4'd0) begin n_errors++; $display("FAIL wrap_16: got %0d want 0", count); end
            end
            if (i == 20) begin
                n_checks++; if (count !== 4'd1) begin n_errors++; $display("FAIL wrap_17: got %0d want 1", count); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_latency();
        int lat0 = -1;
        int lat1 = -1;
        int lat4 = -1;
        do_reset();
        bus.i_in_valid = 1'b1;  bus.i_rs1_data = 32'd9;   bus.i_rs2_data = 32'd2;  bus.i_id = 4'd3;
        bus1.i_in_valid = 1'b1; bus1.i_rs1_data = 8'h80;  bus1.i_rs2_data = 8'h01; bus1.i_signed = 1'b1; bus1.i_id = 4'd7;
        bus4.i_in_valid = 1'b1; bus4.i_rs1_data = 8'h80;  bus4.i_rs2_data = 8'h01; bus4.i_signed = 1'b0; bus4.i_id = 4'd12;
        @(posedge clk); #1;
        idle_all();
        for (int c = 1; c <= 10; c++) begin
            #1;
            if (bus.o_out_valid && lat0 < 0) begin
                lat0 = c;
                n_checks++; if ({bus.o_less, bus.o_equal, bus.o_greater, bus.o_id} !== {3'b001, 4'd3}) begin n_errors++; $display("FAIL lat2_result: got %b want 0010011", {bus.o_less, bus.o_equal, bus.o_greater, bus.o_id}); end
            end
            if (bus1.o_out_valid && lat1 < 0) begin
                lat1 = c;
                n_checks++; if ({bus1.o_less, bus1.o_equal, bus1.o_greater, bus1.o_id} !== {3'b100, 4'd7}) begin n_errors++; $display("FAIL lat1_result: got %b want 1000111", {bus1.o_less, bus1.o_equal, bus1.o_greater, bus1.o_id}); end
            end
            if (bus4.o_out_valid && lat4 < 0) begin
                lat4 = c;
                n_checks++; if ({bus4.o_less, bus4.o_equal, bus4.o_greater, bus4.o_id} !== {3'b001, 4'd12}) begin n_errors++; $display("FAIL lat4_result: got %b want 0011100", {bus4.o_less, bus4.o_equal, bus4.o_greater, bus4.o_id}); end
            end
            @(posedge clk); #1;
        end
        n_checks++; if (lat0 != 2) begin n_errors++; $display("FAIL latency_2: got %0d want 2", lat0); end
        n_checks++; if (lat1 != 1) begin n_errors++; $display("FAIL latency_1: got %0d want 1", lat1); end
        n_checks++; if (lat4 != 4) begin n_errors++; $display("FAIL latency_4: got %0d want 4", lat4); end
        n_checks++; if (count1 !== 8'd1 || count4 !== 8'd1) begin n_errors++; $display("FAIL latency_counts: got %0d/%0d want 1/1", count1, count4); end
    endtask

    task automatic test_random_sweep();
        logic [6:0] sb [$];
        logic [6:0] exp_r;
        logic [3:0] seq  = '0;
        int         rcvd = 0;
        do_reset();
        for (int cyc = 0; cyc < 90; cyc++) begin
            if (cyc < 70) begin
                bus4.i_in_valid  = ($urandom_range(0, 3) != 0);
                bus4.i_rs1_data  = 8'($urandom);
                bus4.i_rs2_data  = ($urandom_range(0, 3) == 0) ? bus4.i_rs1_data : 8'($urandom);
                bus4.i_signed    = 1'($urandom);
                bus4.i_out_ready = 1'($urandom);
            end else begin
                bus4.i_in_valid  = 1'b0;
                bus4.i_out_ready = 1'b1;
            end
            bus4.i_id = seq;
            #1;
            if (!bus4.o_out_valid) begin
                n_checks++; if ({bus4.o_less, bus4.o_equal, bus4.o_greater} !== 3'b000) begin n_errors++; $display("FAIL sweep_idle_flags[c%0d]: got %b want 000", cyc, {bus4.o_less, bus4.o_equal, bus4.o_greater}); end
            end else if (bus4.i_out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++; $display("FAIL sweep_extra[c%0d]: got id %0d want no result", cyc, bus4.o_id);
                end else begin
                    exp_r = sb.pop_front();
                    if ({bus4.o_less, bus4.o_equal, bus4.o_greater, bus4.o_id} !== exp_r) begin n_errors++; $display("FAIL sweep_result[c%0d]: got %b want %b", cyc, {bus4.o_less, bus4.o_equal, bus4.o_greater, bus4.o_id}, exp_r); end
                end
                rcvd++;
            end
            if (bus4.i_in_valid && bus4.o_in_ready) begin
                sb.push_back({ref_cmp(bus4.i_rs1_data, bus4.i_rs2_data, bus4.i_signed), seq});
                seq++;
            end
            @(posedge clk); #1;
        end
        n_checks++; if (sb.size() != 0) begin n_errors++; $display("FAIL sweep_lost: got %0d pending want 0", sb.size()); end
        n_checks++; if (count4 !== 8'(rcvd)) begin n_errors++; $display("FAIL sweep_count: got %0d want %0d", count4, 8'(rcvd)); end
    endtask

    initial begin
        test_reset();
        test_unsigned_basic();
        test_signed_modes();
        test_back_to_back();
        test_reset_mid();
        test_count_wrap();
        test_latency();
        test_random_sweep();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
